ir_nec_rx: RTL
==============

IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter TOL_PCT, default 25, allowed +/- percent deviation on every measured duration.
REQ-003 Parameter N_KEYS, default 4, number of mapped key outputs (1..16).
REQ-004 Parameter KEY_CODES, default {8'h08,8'h5E,8'h18,8'h0C}, N_KEYS*8 bits, slice k = command for key k.
REQ-005 Parameter HOLD_MS, default 120, key-hold time after last frame or repeat.
REQ-006 Parameter CHECK_ADDR, default 1, 1 = enforce address complement byte.
REQ-007 clk  in  1  system clock; one clock domain.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 IR  in  1  asynchronous demodulated IR line, idle high, mark = low.
REQ-010 frame_valid  out  1  one-cycle pulse, new frame accepted.
REQ-011 frame  out  32  raw frame, bit 0 = first received bit.
REQ-012 addr, cmd  out  8 each  frame[7:0], frame[23:16]; held until next accepted frame.
REQ-013 repeat_pulse  out  1  one-cycle pulse, valid repeat code.
REQ-014 frame_err  out  1  one-cycle pulse, any decode abort.
REQ-015 key_n  out  N_KEYS  active-low key outputs.
REQ-016 key_any  out  1  high while any key_n bit is low.

Function
REQ-017 IR passes a 2-flop synchronizer plus 1 edge-detect flop; all flops reset to 1; rise/fall are one-cycle strobes.
REQ-018 UNIT = CLK_HZ*5625/10_000_000 cycles (562.5 us, integer floor); a duration of n units matches when within n*UNIT*(100±TOL_PCT)/100.
REQ-019 Duration counter clears on every edge, counts cycles, saturates at 20*UNIT; width = clog2(20*UNIT+1).
REQ-020 FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK.
REQ-021 IDLE -> LEAD_MARK on fall.
REQ-022 LEAD_MARK on rise: 16 units -> LEAD_SPACE, else error.
REQ-023 LEAD_SPACE on fall: 8 units -> BIT_MARK with bit count 0; 4 units -> RPT_MARK; else error.
REQ-024 BIT_MARK on rise: 1 unit -> BIT_SPACE, else error.
REQ-025 BIT_SPACE on fall: 1 unit shifts in 0, 3 units shifts in 1, LSB first (bit i -> shift[i]); other -> error; after bit 31 -> STOP_MARK, else BIT_MARK.
REQ-026 STOP_MARK on rise: 1 unit and checks pass -> frame/addr/cmd update, frame_valid pulse, -> IDLE; else error.
REQ-027 Checks: frame[31:24] == ~frame[23:16]; if CHECK_ADDR, frame[15:8] == ~frame[7:0].
REQ-028 RPT_MARK on rise: 1 unit -> repeat_pulse only if a frame was accepted and hold timer nonzero; -> IDLE; else error.
REQ-029 Error: frame_err pulse, -> IDLE, outputs addr/cmd/frame unchanged; also taken when counter saturates in any non-IDLE state.
REQ-030 Hold timer loads HOLD_MS*CLK_HZ/1000 on frame_valid or repeat_pulse, decrements to 0, clears the key latch at 0.
REQ-031 On frame_valid, key_n[k] = 0 iff cmd == KEY_CODES slice k, others 1; all keys 1 when no match.
REQ-032 A new frame replaces the latched key in the same cycle; repeat only reloads the timer.
REQ-033 Output latency: frame_valid/repeat_pulse/frame_err assert 1 cycle after the qualifying synchronized edge; key_n updates the same cycle as frame_valid.

Reset
REQ-034 rst sampled on clk: FSM IDLE, counters/timer 0, frame/addr/cmd 0, pulses 0, key_n all 1, key_any 0, sync flops 1.
REQ-035 rst mid-frame discards partial data, no frame_err pulse; decode restarts at the next fall after rst deasserts.

Structure
REQ-036 Shared package ir_pkg: state enum, UNIT/tolerance computation functions, NEC unit counts (16, 8, 4, 3, 1).
REQ-037 One sub-module ir_dur_match: takes count and unit multiple, returns match flag; instantiated per checked duration.

Verification (CLK_HZ=1_000_000, UNIT=562)
REQ-038 Frame addr 0x00, cmd 0x18 -> one frame_valid, frame=0xE718FF00, key_n=4'b1011, key_any=1.
REQ-039 Same frame + repeat code 108 ms later -> repeat_pulse, key_n held low; nothing after -> key_n=4'b1111 120 ms after repeat.
REQ-040 Frame with cmd byte 0x18 and inverse 0xE6 -> frame_err, no frame_valid, outputs unchanged.
REQ-041 Lead mark 6 ms -> frame_err, IDLE; following valid frame decodes normally.
REQ-042 IR held low 15 ms mid-bit -> saturation frame_err; repeat code with no prior frame -> no repeat_pulse.
REQ-043 rst pulse during bit 20 -> no pulses, key_n=all 1; next full frame accepted.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared NEC IR receiver definitions: decoder states, NEC timing unit counts
// and the cycle-domain helpers used to build duration windows.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_MARK
    } ir_state_e;

    // NEC durations in multiples of the 562.5 us base unit
    localparam int U_LEAD_MARK  = 16;
    localparam int U_LEAD_SPACE = 8;
    localparam int U_RPT_SPACE  = 4;
    localparam int U_ONE_SPACE  = 3;
    localparam int U_BIT        = 1;
    localparam int U_SAT        = 20;

    function automatic longint unit_cycles(input longint clk_hz);
        return clk_hz * 5625 / 10_000_000;
    endfunction

    function automatic longint dur_lo(input longint unit, input longint n, input longint tol);
        return n * unit * (100 - tol) / 100;
    endfunction

    function automatic longint dur_hi(input longint unit, input longint n, input longint tol);
        return n * unit * (100 + tol) / 100;
    endfunction

endpackage

// File: rtl/ir_dur_match.sv
// Flags whether a measured duration lies inside the tolerance window of
// N_UNITS base units.
module ir_dur_match import ir_pkg::*; #(
    parameter int     CW      = 10,
    parameter longint UNIT    = 28,
    parameter int     N_UNITS = 1,
    parameter int     TOL_PCT = 25
) (
    input  logic [CW-1:0] cnt,
    output logic          match
);

    localparam logic [63:0] LO = 64'(dur_lo(UNIT, N_UNITS, TOL_PCT));
    localparam logic [63:0] HI = 64'(dur_hi(UNIT, N_UNITS, TOL_PCT));

    logic [63:0] cnt_w;

    assign cnt_w = {{(64-CW){1'b0}}, cnt};
    assign match = (cnt_w >= LO) && (cnt_w <= HI);

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder: synchronizes the demodulated line, times each
// mark/space, assembles 32-bit frames and drives hold-timed key outputs.
module ir_nec_rx import ir_pkg::*; #(
    parameter int                  CLK_HZ     = 50_000_000,
    parameter int                  TOL_PCT    = 25,
    parameter int                  N_KEYS     = 4,
    parameter logic [N_KEYS*8-1:0] KEY_CODES  = {8'h08, 8'h5E, 8'h18, 8'h0C},
    parameter int                  HOLD_MS    = 120,
    parameter bit                  CHECK_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IR,
    output logic              frame_valid,
    output logic [31:0]       frame,
    output logic [7:0]        addr,
    output logic [7:0]        cmd,
    output logic              repeat_pulse,
    output logic              frame_err,
    output logic [N_KEYS-1:0] key_n,
    output logic              key_any
);

    localparam longint UNIT = unit_cycles(CLK_HZ);
    localparam longint SAT  = U_SAT * UNIT;
    localparam int     CW   = $clog2(SAT + 1);
    localparam longint HOLD = longint'(HOLD_MS) * CLK_HZ / 1000;
    localparam int     TW   = $clog2(HOLD + 1);

    localparam logic [CW-1:0] SAT_C  = CW'(SAT);
    localparam logic [TW-1:0] HOLD_C = TW'(HOLD);
    localparam int            MULT [5] = '{U_LEAD_MARK, U_LEAD_SPACE, U_RPT_SPACE, U_ONE_SPACE, U_BIT};

    logic            s1, s2, s3;
    logic            fall, rise;
    logic [CW-1:0]   cnt;
    logic [4:0]      hit;
    logic            m16, m8, m4, m3, m1;

    ir_state_e       state, state_d;
    logic [4:0]      bit_cnt, bit_cnt_d;
    logic [31:0]     shreg, shreg_d;
    logic            acc, rpt, err, checks_ok;
    logic            have_frame;
    logic [TW-1:0]   hold;
    logic [N_KEYS-1:0] key_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3} <= 3'b111;
        end else begin
            s1 <= IR;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;
    assign rise = ~s3 & s2;

    always_ff @(posedge clk) begin
        if (rst || fall || rise) cnt <= '0;
        else if (cnt != SAT_C)   cnt <= cnt + 1'b1;
    end

    for (genvar g = 0; g < 5; g++) begin : g_match
        ir_dur_match #(
            .CW      (CW),
            .UNIT    (UNIT),
            .N_UNITS (MULT[g]),
            .TOL_PCT (TOL_PCT)
        ) u_match (
            .cnt   (cnt),
            .match (hit[g])
        );
    end

    assign {m1, m3, m4, m8, m16} = hit;

    assign checks_ok = (shreg[31:24] == ~shreg[23:16]) &&
                       (!CHECK_ADDR || (shreg[15:8] == ~shreg[7:0]));

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        acc       = 1'b0;
        rpt       = 1'b0;
        err       = 1'b0;
        if (state != IDLE && cnt == SAT_C) begin
            err = 1'b1;
        end else begin
            case (state)
                IDLE:       if (fall) state_d = LEAD_MARK;
                LEAD_MARK:  if (rise) begin
                                if (m16) state_d = LEAD_SPACE;
                                else     err = 1'b1;
                            end
                LEAD_SPACE: if (fall) begin
                                if (m8) begin
                                    state_d   = BIT_MARK;
                                    bit_cnt_d = '0;
                                end else if (m4) begin
                                    state_d = RPT_MARK;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                BIT_MARK:   if (rise) begin
                                if (m1) state_d = BIT_SPACE;
                                else    err = 1'b1;
                            end
                BIT_SPACE:  if (fall) begin
                                if (m1 || m3) begin
                                    shreg_d[bit_cnt] = m3;
                                    bit_cnt_d        = bit_cnt + 1'b1;
                                    state_d          = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                STOP_MARK:  if (rise) begin
                                if (m1 && checks_ok) begin
                                    acc     = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                RPT_MARK:   if (rise) begin
                                if (m1) begin
                                    rpt     = have_frame && (hold != '0);
                                    state_d = IDLE;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                default:    state_d = IDLE;
            endcase
        end
        if (err) state_d = IDLE;
    end

    // KEY_CODES is listed key 0 first, so key k sits k bytes down from the MSB
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        assign key_hit[k] = (shreg[23:16] == KEY_CODES[(N_KEYS-1-k)*8 +: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            frame_valid  <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_err    <= 1'b0;
            frame        <= '0;
            addr         <= '0;
            cmd          <= '0;
            have_frame   <= 1'b0;
            hold         <= '0;
            key_n        <= '1;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            shreg        <= shreg_d;
            frame_valid  <= acc;
            repeat_pulse <= rpt;
            frame_err    <= err;
            if (acc) begin
                frame      <= shreg;
                addr       <= shreg[7:0];
                cmd        <= shreg[23:16];
                have_frame <= 1'b1;
                hold       <= HOLD_C;
                key_n      <= ~key_hit;
            end else if (rpt) begin
                hold <= HOLD_C;
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
                if (hold == 1) key_n <= '1;
            end
        end
    end

    assign key_any = ~&key_n;

endmodule
